// File: rtl/multicycle_seq.sv
// multicycle_seq -- control sequencer for a multicycle RISC-V style datapath.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// raises the datapath strobes for each step. Illegal opcodes and memories that
// stay not-ready for too long park the sequencer in TRAP until reset.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset
//   op          : 7-bit opcode from the instruction register
//   imem_ready  : instruction memory returned data this cycle
//   dmem_ready  : data memory completed the access this cycle
//   imem_req    : instruction fetch request (Moore)
//   ir_we       : instruction register load (Mealy on imem_ready in FETCH)
//   dmem_req    : data memory request (Moore)
//   dmem_we     : data memory write qualifier (Moore, only with dmem_req)
//   reg_we      : register file write strobe
//   pc_we       : PC update strobe (Mealy on dmem_ready in MEM)
//   state       : current state encoding
//   halted      : sequencer sits in TRAP
//   trap_cause  : 00 none, 01 illegal opcode, 10 bus timeout
//   retired     : count of cycles with pc_we=1, wraps at 2^32
module multicycle_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  function automatic logic is_legal_op(input logic [6:0] o);
    logic legal;
    case (o)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_IMM, OP_OP, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  wait_cnt_r;
  logic [1:0]  trap_cause_r;
  logic [31:0] retired_r;
  logic [1:0]  cause_s;
  logic        imem_req_s;
  logic        ir_we_s;
  logic        dmem_req_s;
  logic        dmem_we_s;
  logic        reg_we_s;
  logic        pc_we_s;
  logic        waiting_s;

  // Next-state and strobe decode for the current state and ready inputs.
  always_comb begin
    next_state_s = state_r;
    cause_s      = 2'b00;
    imem_req_s   = 1'b0;
    ir_we_s      = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    reg_we_s     = 1'b0;
    pc_we_s      = 1'b0;
    waiting_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_we_s      = 1'b1;
          next_state_s = S_DECODE;
        end else if (wait_cnt_r == TIMEOUT_CNT) begin
          next_state_s = S_TRAP;
          cause_s      = CAUSE_TIMEOUT;
        end else begin
          waiting_s    = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal_op(op)) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_TRAP;
          cause_s      = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if ((op == OP_LOAD) || (op == OP_STORE)) begin
          next_state_s = S_MEM;
        end else if (op == OP_BRANCH) begin
          pc_we_s      = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (op == OP_STORE);
        if (dmem_ready) begin
          if (op == OP_STORE) begin
            pc_we_s      = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_WB;
          end
        end else if (wait_cnt_r == TIMEOUT_CNT) begin
          next_state_s = S_TRAP;
          cause_s      = CAUSE_TIMEOUT;
        end else begin
          waiting_s    = 1'b1;
        end
      end
      S_WB: begin
        reg_we_s     = 1'b1;
        pc_we_s      = 1'b1;
        next_state_s = S_FETCH;
      end
      S_TRAP: begin
        next_state_s = S_TRAP;
      end
      default: begin
        // Unused encodings 6 and 7 are treated as a corrupted state.
        next_state_s = S_TRAP;
        cause_s      = CAUSE_ILLEGAL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Wait counter: zero on any state change, counts not-ready cycles in FETCH/MEM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r <= 4'd0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= 4'd0;
    end else if (waiting_s) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Trap cause is captured only on the transition into TRAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_cause_r <= 2'b00;
    end else if ((next_state_s == S_TRAP) && (state_r != S_TRAP)) begin
      trap_cause_r <= cause_s;
    end else begin
      trap_cause_r <= trap_cause_r;
    end
  end

  // Retired-instruction counter, one per PC update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_r <= 32'd0;
    end else if (pc_we_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Strobes are suppressed while reset is low so an interrupted access
  // cannot commit anything in the reset cycle.
  assign imem_req   = imem_req_s & rst_n;
  assign ir_we      = ir_we_s    & rst_n;
  assign dmem_req   = dmem_req_s & rst_n;
  assign dmem_we    = dmem_we_s  & rst_n;
  assign reg_we     = reg_we_s   & rst_n;
  assign pc_we      = pc_we_s    & rst_n;
  assign state      = state_r;
  assign halted     = (state_r == S_TRAP);
  assign trap_cause = trap_cause_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_seq.sv
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_we;
  logic        pc_we;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] retired;

  multicycle_seq #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .pc_we(pc_we),
    .state(state), .halted(halted), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  // States
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;
  // Strobe patterns {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] IFW  = 6'b100000;
  localparam logic [5:0] IFR  = 6'b110000;
  localparam logic [5:0] BRS  = 6'b000001;
  localparam logic [5:0] WBS  = 6'b000011;
  localparam logic [5:0] LDS  = 6'b001000;
  localparam logic [5:0] STW  = 6'b001100;
  localparam logic [5:0] STR  = 6'b001101;
  // Opcodes
  localparam logic [6:0] ALU = 7'b0110011, BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011, JAL = 7'b1101111, OPI = 7'b0010011;
  localparam logic [6:0] ILL = 7'b1111111;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  stb;
    logic        hlt;
    logic [1:0]  cause;
    logic [31:0] ret;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic rst, input logic [6:0] o, input logic ir,
                      input logic dr, input string nm, input logic [2:0] st,
                      input logic [5:0] stb, input logic hlt,
                      input logic [1:0] cause, input logic [31:0] ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; op = o; imem_ready = ir; dmem_ready = dr;
    e.st = st; e.stb = stb; e.hlt = hlt; e.cause = cause; e.ret = ret;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.st = state;
      a.stb = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we};
      a.hlt = halted; a.cause = trap_cause; a.ret = retired;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got st=%0d stb=%b halted=%b cause=%b retired=%0d, expected st=%0d stb=%b halted=%b cause=%b retired=%0d",
                 nm, a.st, a.stb, a.hlt, a.cause, a.ret, e.st, e.stb, e.hlt, e.cause, e.ret);
      end
    end
  end

  initial begin
    rst_n = 1'b0; op = 7'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (3) @(posedge clk);

    step(1'b0, ALU, 1'b1, 1'b0, "reset", F, NONE, 1'b0, 2'b00, 32'd0);
    // ALU op: F D E WB
    step(1'b1, ALU, 1'b1, 1'b0, "alu_fetch",  F, IFR,  1'b0, 2'b00, 32'd0);
    step(1'b1, ALU, 1'b0, 1'b0, "alu_decode", D, NONE, 1'b0, 2'b00, 32'd0);
    step(1'b1, ALU, 1'b0, 1'b0, "alu_exec",   E, NONE, 1'b0, 2'b00, 32'd0);
    step(1'b1, ALU, 1'b0, 1'b0, "alu_wb",     W, WBS,  1'b0, 2'b00, 32'd0);
    // Branch: F D E(pc_we)
    step(1'b1, BR, 1'b1, 1'b0, "br_fetch",  F, IFR,  1'b0, 2'b00, 32'd1);
    step(1'b1, BR, 1'b0, 1'b0, "br_decode", D, NONE, 1'b0, 2'b00, 32'd1);
    step(1'b1, BR, 1'b0, 1'b0, "br_exec",   E, BRS,  1'b0, 2'b00, 32'd1);
    // Load, ready on 3rd MEM cycle
    step(1'b1, LD, 1'b1, 1'b0, "ld_fetch",  F, IFR,  1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b0, "ld_decode", D, NONE, 1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b0, "ld_exec",   E, NONE, 1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b0, "ld_mem1",   M, LDS,  1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b0, "ld_mem2",   M, LDS,  1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b1, "ld_mem3",   M, LDS,  1'b0, 2'b00, 32'd2);
    step(1'b1, LD, 1'b0, 1'b0, "ld_wb",     W, WBS,  1'b0, 2'b00, 32'd2);
    // Store, ready immediately
    step(1'b1, ST, 1'b1, 1'b0, "st_fetch",  F, IFR,  1'b0, 2'b00, 32'd3);
    step(1'b1, ST, 1'b0, 1'b0, "st_decode", D, NONE, 1'b0, 2'b00, 32'd3);
    step(1'b1, ST, 1'b0, 1'b0, "st_exec",   E, NONE, 1'b0, 2'b00, 32'd3);
    step(1'b1, ST, 1'b0, 1'b1, "st_mem",    M, STR,  1'b0, 2'b00, 32'd3);
    // jal with two fetch wait cycles
    step(1'b1, JAL, 1'b0, 1'b0, "jal_wait1",  F, IFW,  1'b0, 2'b00, 32'd4);
    step(1'b1, JAL, 1'b0, 1'b0, "jal_wait2",  F, IFW,  1'b0, 2'b00, 32'd4);
    step(1'b1, JAL, 1'b1, 1'b0, "jal_fetch",  F, IFR,  1'b0, 2'b00, 32'd4);
    step(1'b1, JAL, 1'b0, 1'b0, "jal_decode", D, NONE, 1'b0, 2'b00, 32'd4);
    step(1'b1, JAL, 1'b0, 1'b0, "jal_exec",   E, NONE, 1'b0, 2'b00, 32'd4);
    step(1'b1, JAL, 1'b0, 1'b0, "jal_wb",     W, WBS,  1'b0, 2'b00, 32'd4);
    // Reset in the middle of a load access with retired=5
    step(1'b1, LD, 1'b1, 1'b0, "rstmem_fetch",  F, IFR,  1'b0, 2'b00, 32'd5);
    step(1'b1, LD, 1'b0, 1'b0, "rstmem_decode", D, NONE, 1'b0, 2'b00, 32'd5);
    step(1'b1, LD, 1'b0, 1'b0, "rstmem_exec",   E, NONE, 1'b0, 2'b00, 32'd5);
    step(1'b1, LD, 1'b0, 1'b0, "rstmem_mem",    M, LDS,  1'b0, 2'b00, 32'd5);
    step(1'b0, LD, 1'b0, 1'b1, "rstmem_reset",  M, NONE, 1'b0, 2'b00, 32'd5);
    // First cycle after reset is FETCH cycle 1 of a fetch timeout run
    step(1'b1, LD, 1'b0, 1'b0, "rstmem_after",  F, IFW,  1'b0, 2'b00, 32'd0);
    for (int i = 2; i <= 16; i++)
      step(1'b1, LD, 1'b0, 1'b0, "ftimeout_wait", F, IFW, 1'b0, 2'b00, 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, LD, 1'b1, 1'b0, "ftimeout_trap", T, NONE, 1'b1, 2'b10, 32'd0);
    step(1'b0, OPI, 1'b0, 1'b0, "ftimeout_reset", T, NONE, 1'b1, 2'b10, 32'd0);
    // Fetch ready on the 16th cycle: no trap
    for (int i = 1; i <= 15; i++)
      step(1'b1, OPI, 1'b0, 1'b0, "fready_wait", F, IFW, 1'b0, 2'b00, 32'd0);
    step(1'b1, OPI, 1'b1, 1'b0, "fready_16",     F, IFR,  1'b0, 2'b00, 32'd0);
    step(1'b1, OPI, 1'b0, 1'b0, "fready_decode", D, NONE, 1'b0, 2'b00, 32'd0);
    step(1'b1, OPI, 1'b0, 1'b0, "fready_exec",   E, NONE, 1'b0, 2'b00, 32'd0);
    step(1'b1, OPI, 1'b0, 1'b0, "fready_wb",     W, WBS,  1'b0, 2'b00, 32'd0);
    // Store whose data memory never answers: MEM timeout
    step(1'b1, ST, 1'b1, 1'b0, "mtimeout_fetch",  F, IFR,  1'b0, 2'b00, 32'd1);
    step(1'b1, ST, 1'b0, 1'b0, "mtimeout_decode", D, NONE, 1'b0, 2'b00, 32'd1);
    step(1'b1, ST, 1'b0, 1'b0, "mtimeout_exec",   E, NONE, 1'b0, 2'b00, 32'd1);
    for (int i = 1; i <= 16; i++)
      step(1'b1, ST, 1'b0, 1'b0, "mtimeout_wait", M, STW, 1'b0, 2'b00, 32'd1);
    step(1'b1, ST, 1'b0, 1'b1, "mtimeout_trap",  T, NONE, 1'b1, 2'b10, 32'd1);
    step(1'b0, ILL, 1'b0, 1'b0, "mtimeout_reset", T, NONE, 1'b1, 2'b10, 32'd1);
    // Illegal opcode: trap and hold for 20 cycles
    step(1'b1, ILL, 1'b1, 1'b0, "ill_fetch",  F, IFR,  1'b0, 2'b00, 32'd0);
    step(1'b1, ILL, 1'b1, 1'b1, "ill_decode", D, NONE, 1'b0, 2'b00, 32'd0);
    for (int i = 0; i < 20; i++)
      step(1'b1, ILL, 1'b1, 1'b1, "ill_trap_hold", T, NONE, 1'b1, 2'b01, 32'd0);

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
